// File: rtl/vjtag_uart_pkg.sv
// rtl/vjtag_uart_pkg.sv - shared constants and TX drain FSM encoding for vjtag_uart_ctrl
package vjtag_uart_pkg;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } tx_state_t;

endpackage

// File: rtl/vjtag_byte_fifo.sv
// rtl/vjtag_byte_fifo.sv - byte FIFO with AW+1 bit pointers; push when full succeeds if a pop frees the slot
module vjtag_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge m_clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vjtag_uart_ctrl.sv
// rtl/vjtag_uart_ctrl.sv - VirtualJTAG byte link controller: TX round-robin arbiter, TX drain FSM, RX buffer, status
module vjtag_uart_ctrl
  import vjtag_uart_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       l_recv_init,
  input  logic       l_recv,
  input  logic [7:0] l_recv_data,
  input  logic       l_send_init,
  input  logic       l_send_ready,
  output logic       l_send,
  output logic [7:0] l_send_data,
  input  logic       tx0_valid,
  input  logic [7:0] tx0_data,
  output logic       tx0_ready,
  input  logic       tx1_valid,
  input  logic [7:0] tx1_data,
  output logic       tx1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overflow,
  output logic [7:0] tx_underrun,
  output logic [7:0] rx_sessions,
  input  logic       clr_status
);

  tx_state_t  state;
  logic       pending;
  logic       last_grant;
  logic       service;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_push;
  logic       tx_pop;
  logic       can_push;
  logic       grant0;
  logic       grant1;
  logic [7:0] tx_din;
  logic [7:0] tx_head;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_drop;
  logic       unused_inputs;

  // The link raises send_ready at session start, so send_init carries no extra meaning.
  assign unused_inputs = l_send_init;

  assign service  = (state == IDLE) && (l_send_ready || pending);
  assign tx_pop   = service && !tx_empty;
  assign can_push = !tx_full || tx_pop;
  assign grant0   = can_push && tx0_valid && (!tx1_valid || last_grant);
  assign grant1   = can_push && tx1_valid && (!tx0_valid || !last_grant);
  assign tx_push  = grant0 || grant1;
  assign tx_din   = grant1 ? tx1_data : tx0_data;
  assign tx0_ready = grant0;
  assign tx1_ready = grant1;

  vjtag_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .push    (tx_push),
    .din     (tx_din),
    .pop     (tx_pop),
    .dout    (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  vjtag_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .push    (l_recv),
    .din     (l_recv_data),
    .pop     (rx_ready),
    .dout    (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign rx_valid = !rx_empty;
  assign rx_drop  = l_recv && rx_full && !rx_ready;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      l_send      <= 1'b0;
      l_send_data <= 8'h00;
      tx_underrun <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (service) begin
            state   <= LOAD;
            l_send  <= 1'b1;
            // Servicing the pending request while a fresh pulse arrives re-arms it.
            pending <= pending && l_send_ready;
            if (!tx_empty) begin
              l_send_data <= tx_head;
              if (clr_status) tx_underrun <= 8'h00;
            end else begin
              l_send_data <= FILL_BYTE;
              if (clr_status)                tx_underrun <= 8'h01;
              else if (tx_underrun != 8'hFF) tx_underrun <= tx_underrun + 8'h01;
            end
          end else begin
            l_send <= 1'b0;
            if (clr_status) tx_underrun <= 8'h00;
          end
        end
        LOAD: begin
          state  <= IDLE;
          l_send <= 1'b0;
          if (l_send_ready) pending <= 1'b1;
          if (clr_status)   tx_underrun <= 8'h00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      last_grant  <= 1'b1;
      rx_overflow <= 1'b0;
      rx_sessions <= 8'h00;
    end else begin
      if (tx_push)          last_grant  <= grant1;
      if (rx_drop)          rx_overflow <= 1'b1;
      else if (clr_status)  rx_overflow <= 1'b0;
      if (l_recv_init)      rx_sessions <= rx_sessions + 8'h01;
    end
  end

endmodule

// File: tb/tb_vjtag_uart_ctrl.sv
// tb/tb_vjtag_uart_ctrl.sv - directed table-driven bench for vjtag_uart_ctrl
module tb_vjtag_uart_ctrl;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       l_recv_init, l_recv, l_send_init, l_send_ready;
  logic [7:0] l_recv_data;
  logic       l_send;
  logic [7:0] l_send_data;
  logic       tx0_valid, tx1_valid, tx0_ready, tx1_ready;
  logic [7:0] tx0_data, tx1_data;
  logic       rx_valid, rx_ready, rx_overflow, clr_status;
  logic [7:0] rx_data, tx_underrun, rx_sessions;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
  } arb_vec_t;

  arb_vec_t   vecs [10];
  logic [7:0] exp_tx [9];

  always #5 m_clock = ~m_clock;

  vjtag_uart_ctrl dut (
    .m_clock      (m_clock),
    .p_reset      (p_reset),
    .l_recv_init  (l_recv_init),
    .l_recv       (l_recv),
    .l_recv_data  (l_recv_data),
    .l_send_init  (l_send_init),
    .l_send_ready (l_send_ready),
    .l_send       (l_send),
    .l_send_data  (l_send_data),
    .tx0_valid    (tx0_valid),
    .tx0_data     (tx0_data),
    .tx0_ready    (tx0_ready),
    .tx1_valid    (tx1_valid),
    .tx1_data     (tx1_data),
    .tx1_ready    (tx1_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_overflow  (rx_overflow),
    .tx_underrun  (tx_underrun),
    .rx_sessions  (rx_sessions),
    .clr_status   (clr_status)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  // One send_ready pulse; l_send must be high exactly in the following cycle.
  task automatic send_pulse(input logic [7:0] exp, input logic do_chk);
    l_send_ready = 1'b1;
    tick();
    l_send_ready = 1'b0;
    if (do_chk) begin
      chk1("l_send_strobe", l_send, 1'b1);
      chk8("l_send_data", l_send_data, exp);
    end
    tick();
    if (do_chk) chk1("l_send_low", l_send, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk1({tag, "_l_send"}, l_send, 1'b0);
    chk8({tag, "_l_send_data"}, l_send_data, 8'h00);
    chk1({tag, "_tx0_ready"}, tx0_ready, 1'b0);
    chk1({tag, "_tx1_ready"}, tx1_ready, 1'b0);
    chk1({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk1({tag, "_rx_overflow"}, rx_overflow, 1'b0);
    chk8({tag, "_tx_underrun"}, tx_underrun, 8'h00);
    chk8({tag, "_rx_sessions"}, rx_sessions, 8'h00);
  endtask

  initial begin
    p_reset = 1'b1;
    l_recv_init = 1'b0; l_recv = 1'b0; l_recv_data = 8'h00;
    l_send_init = 1'b0; l_send_ready = 1'b0;
    tx0_valid = 1'b0; tx0_data = 8'h00; tx1_valid = 1'b0; tx1_data = 8'h00;
    rx_ready = 1'b0; clr_status = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h20, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h21, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h12, 8'h21, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h12, 8'h30, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'h12, 8'h31, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h13, 8'h31, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h13, 8'h32, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h13, 8'h32, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 8'h14, 8'h32, 1'b0, 1'b1};
    exp_tx = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h30, 8'h12, 8'h31, 8'h13, 8'h32};

    tick();
    tick();
    p_reset = 1'b0;
    check_reset_state("rst");

    // Arbitration table: grants follow last_grant, starting with requester 0.
    for (int i = 0; i < 10; i++) begin
      tx0_valid = vecs[i].v0; tx0_data = vecs[i].d0;
      tx1_valid = vecs[i].v1; tx1_data = vecs[i].d1;
      @(negedge m_clock);
      chk1($sformatf("arb%0d_tx0_ready", i), tx0_ready, vecs[i].r0);
      chk1($sformatf("arb%0d_tx1_ready", i), tx1_ready, vecs[i].r1);
      tick();
    end
    tx0_valid = 1'b0; tx1_valid = 1'b0;

    for (int i = 0; i < 9; i++) send_pulse(exp_tx[i], 1'b1);

    // Empty FIFO: fill byte and saturating underrun count.
    send_pulse(8'h00, 1'b1);
    chk8("underrun_first", tx_underrun, 8'h01);
    for (int i = 0; i < 299; i++) send_pulse(8'h00, 1'b0);
    chk8("underrun_sat", tx_underrun, 8'hFF);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk8("underrun_clr", tx_underrun, 8'h00);
    clr_status = 1'b1;
    l_send_ready = 1'b1;
    tick();
    clr_status = 1'b0;
    l_send_ready = 1'b0;
    chk8("underrun_clr_event", tx_underrun, 8'h01);
    tick();

    // Fill TX FIFO to 16, then push and pop together while full.
    tx0_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx0_data = 8'(8'h40 + i);
      @(negedge m_clock);
      chk1($sformatf("fill%0d_ready", i), tx0_ready, 1'b1);
      tick();
    end
    tx0_data = 8'h50;
    @(negedge m_clock);
    chk1("full_ready_low", tx0_ready, 1'b0);
    chk1("full_ready1_low", tx1_ready, 1'b0);
    tick();
    l_send_ready = 1'b1;
    @(negedge m_clock);
    chk1("full_pushpop_ready", tx0_ready, 1'b1);
    tick();
    l_send_ready = 1'b0;
    tx0_data = 8'h51;
    chk1("full_pushpop_send", l_send, 1'b1);
    chk8("full_pushpop_data", l_send_data, 8'h40);
    @(negedge m_clock);
    chk1("still_full_ready", tx0_ready, 1'b0);
    tick();
    tx0_valid = 1'b0;
    for (int i = 1; i < 16; i++) send_pulse(8'(8'h40 + i), 1'b1);
    send_pulse(8'h50, 1'b1);
    send_pulse(8'h00, 1'b1);
    chk8("underrun_after_full", tx_underrun, 8'h02);

    // Second send_ready lands in LOAD and must be serviced afterwards.
    tx1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx1_data = 8'(8'h60 + i);
      tick();
    end
    tx1_valid = 1'b0;
    l_send_ready = 1'b1;
    tick();
    chk1("pend_first_send", l_send, 1'b1);
    chk8("pend_first_data", l_send_data, 8'h60);
    tick();
    l_send_ready = 1'b0;
    chk1("pend_gap", l_send, 1'b0);
    tick();
    chk1("pend_second_send", l_send, 1'b1);
    chk8("pend_second_data", l_send_data, 8'h61);
    tick();
    chk1("pend_second_low", l_send, 1'b0);
    send_pulse(8'h62, 1'b1);

    // RX overflow: 17 bytes with the consumer stalled.
    for (int i = 0; i < 17; i++) begin
      l_recv = 1'b1;
      l_recv_data = 8'(i);
      tick();
      if (i == 0) chk1("rx_valid_after_push", rx_valid, 1'b1);
      if (i == 15) chk1("rx_no_overflow_16", rx_overflow, 1'b0);
    end
    l_recv = 1'b0;
    chk1("rx_overflow_set", rx_overflow, 1'b1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk1("rx_overflow_clr", rx_overflow, 1'b0);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge m_clock);
      chk1($sformatf("rx%0d_valid", i), rx_valid, 1'b1);
      chk8($sformatf("rx%0d_data", i), rx_data, 8'(i));
      tick();
    end
    rx_ready = 1'b0;
    chk1("rx_drained", rx_valid, 1'b0);

    // Asynchronous reset with bytes queued on both sides.
    tx0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx0_data = 8'(8'h70 + i);
      tick();
    end
    tx0_valid = 1'b0;
    l_recv = 1'b1; l_recv_data = 8'hAA;
    l_recv_init = 1'b1;
    tick();
    tick();
    l_recv = 1'b0;
    l_recv_init = 1'b0;
    send_pulse(8'h70, 1'b1);
    chk8("sessions_before_reset", rx_sessions, 8'h02);
    #2;
    p_reset = 1'b1;
    #1;
    check_reset_state("async");
    tick();
    p_reset = 1'b0;
    send_pulse(8'h00, 1'b1);
    chk8("post_reset_underrun", tx_underrun, 8'h01);
    for (int i = 0; i < 3; i++) begin
      l_recv_init = 1'b1;
      tick();
      l_recv_init = 1'b0;
      tick();
    end
    chk8("rx_sessions_3", rx_sessions, 8'h03);
    chk1("post_reset_rx_empty", rx_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
